// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle RV32 subset controller.
// Holds the opcode constants, the ALU operation codes, the operand and
// result select encodings, the controller state enum and the ALU decode
// class used between the FSM and its ALU decoder.
package mc_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_ILLEGAL
  } state_t;

  // Which decode rule the ALU decoder applies this cycle.
  typedef enum logic [1:0] {
    CLS_ADDR,
    CLS_RTYPE,
    CLS_ITYPE,
    CLS_BRANCH
  } alu_cls_t;

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation decoder.
// Ports:
//   cls      in  decode class chosen by the controller state
//   funct3   in  instr[14:12]
//   funct7b5 in  instr[30]
//   alu_op   out 3-bit ALU operation
//   legal    out 0 when funct3/funct7b5 is not supported for this class
module mc_alu_dec
  import mc_pkg::*;
(
  input  alu_cls_t   cls,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_op,
  output logic       legal
);

  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (cls)
      CLS_RTYPE: begin
        if (funct3 == F3_ADD)      alu_op = funct7b5 ? ALU_SUB : ALU_ADD;
        else if (funct3 == F3_AND) alu_op = ALU_AND;
        else                       legal  = 1'b0;
      end
      CLS_ITYPE: begin
        // Immediate forms have no SUB; funct7b5 is immediate data here.
        if (funct3 == F3_ADD)      alu_op = ALU_ADD;
        else if (funct3 == F3_AND) alu_op = ALU_AND;
        else                       legal  = 1'b0;
      end
      CLS_BRANCH: begin
        alu_op = ALU_SUB;
        legal  = (funct3 == F3_BEQ);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM for the RV32 subset (lw, sw, add, sub, and,
// addi, andi, beq). Sequences fetch/decode/execute/memory/writeback over
// a shared datapath with one unified memory port, counts retired
// instructions and traps unsupported encodings.
// Ports:
//   clk, reset (async, active-high)
//   opcode, funct3, funct7b5  instruction fields from the IR
//   zero                      ALU zero flag
//   mem_ready                 memory finishes the current access
//   pc_write, ir_write, adr_src, mem_write, reg_write   datapath strobes
//   alu_src_a, alu_src_b, result_src, alu_op            datapath selects
//   instr_done                one-cycle retirement pulse
//   illegal                   high while trapped
//   instret                   retired-instruction count (wraps)
module mc_control
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [2:0]       alu_op,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t   state;
  alu_cls_t alu_cls;
  logic     alu_legal;

  always_comb begin
    alu_cls = CLS_ADDR;
    case (state)
      S_EXECR:  alu_cls = CLS_RTYPE;
      S_EXECI:  alu_cls = CLS_ITYPE;
      S_BRANCH: alu_cls = CLS_BRANCH;
      default:  ;
    endcase
  end

  mc_alu_dec u_alu_dec (
    .cls      (alu_cls),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .alu_op   (alu_op),
    .legal    (alu_legal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      instret <= '0;
    end else begin
      if (instr_done) instret <= instret + CNT_W'(1);
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_RTYPE:          state <= S_EXECR;
            OP_ITYPE:          state <= S_EXECI;
            OP_BRANCH:         state <= S_BRANCH;
            default:           state <= S_ILLEGAL;
          endcase
        end
        S_MEMADR:   state <= (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (mem_ready) state <= S_FETCH;
        S_EXECR,
        S_EXECI:    state <= alu_legal ? S_ALUWB : S_ILLEGAL;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= alu_legal ? S_FETCH : S_ILLEGAL;
        S_ILLEGAL:  state <= S_ILLEGAL;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Moore decode; only the strobes named below look at mem_ready/zero.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    result_src = RES_ALUOUT;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        // Branch target PC_old + imm parks in ALUOut for BRANCH.
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_RDATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      S_EXECR:    alu_src_a = SRC_A_RS1;
      S_EXECI: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = SRC_A_RS1;
        pc_write   = zero & alu_legal;
        instr_done = alu_legal;
      end
      S_ILLEGAL:  illegal = 1'b1;
      default:    ;
    endcase
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control FSM for the RV32 core subset (lw, sw, add, sub, and, addi, andi, beq). It sequences instruction fetch, decode, execute, memory and writeback through the shared datapath. It drives the ALU's 3-bit operation code and operand selects, and handshakes with a single unified memory port. It also counts retired instructions and traps unsupported encodings.

## Interface
- CNT_W, 32, width of retired-instruction counter.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  7  instr[6:0] from instruction register.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes current access this cycle.
- pc_write  out  1  load PC.
- ir_write  out  1  load instruction register and old-PC register.
- adr_src  out  1  0 = PC, 1 = ALUOut drives memory address.
- mem_write  out  1  memory write strobe.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  2  00 PC, 01 old PC, 10 rs1.
- alu_src_b  out  2  00 rs2, 01 immediate, 10 constant 4.
- result_src  out  2  00 ALUOut, 01 read data, 10 ALU result.
- alu_op  out  3  000 ADD, 001 SUB, 010 AND.
- instr_done  out  1  one-cycle pulse on retirement.
- illegal  out  1  sticky trap flag.
- instret  out  CNT_W  retired-instruction count.

## Operation
- Moore FSM. Outputs decode combinationally from the state register. alu_op additionally decodes from funct3/funct7b5 in the EXECUTE states, and pc_write/ir_write/mem_write gate with mem_ready/zero where stated.
- Defaults in every state: all strobes 0, selects 00, alu_op ADD.
- FETCH: src_a=00, src_b=10, result_src=10, adr_src=0. ir_write=pc_write=mem_ready. Stay in FETCH until mem_ready, then go to DECODE.
- DECODE: src_a=01, src_b=01, ADD (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - else → ILLEGAL
- MEMADR: src_a=10, src_b=01, ADD. Go to MEMREAD if lw, else MEMWRITE.
- MEMREAD: adr_src=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, retire, go to FETCH.
- MEMWRITE: adr_src=1, mem_write=1 held until mem_ready, then retire and go to FETCH.
- EXECR: src_a=10, src_b=00.
  - funct3 000 with funct7b5=0 → ADD; with funct7b5=1 → SUB.
  - funct3 111 → AND.
  - Then go to ALUWB; any other funct3 → ILLEGAL.
- EXECI: src_a=10, src_b=01. funct3 000 → ADD, 111 → AND, then go to ALUWB; else → ILLEGAL.
- ALUWB: result_src=00, reg_write=1, retire, go to FETCH.
- BRANCH: src_a=10, src_b=00, SUB, result_src=00, pc_write=zero. Retire and go to FETCH. funct3≠000 → ILLEGAL with no pc_write.
- ILLEGAL: all strobes 0, illegal=1. Absorbing until reset; instret frozen.
- Retire means instr_done=1 for that cycle and instret increments by 1, wrapping modulo 2^CNT_W.

## Timing
- Reset: state FETCH, instret=0, illegal=0. Outputs during reset take the FETCH values with mem_ready gating; no register write or memory write can occur.
- Reset asserted mid-instruction aborts immediately. No retirement is counted for the aborted instruction.
- Latency with zero-wait memory (mem_ready held 1):
  - lw: 5 cycles
  - sw: 4 cycles
  - R/I-type: 4 cycles
  - beq: 3 cycles
- Each wait cycle with mem_ready=0 adds one cycle in FETCH, MEMREAD or MEMWRITE. Strobes stay stable while waiting.
- instret updates on the clock edge ending the retiring state. It is visible the cycle after instr_done.
- mem_ready is ignored in all states except FETCH, MEMREAD and MEMWRITE.

## Structure
- Shared package mc_pkg holds:
  - opcode constants
  - ALU op codes (ADD 000, SUB 001, AND 010)
  - src_a, src_b and result_src encodings
  - state enum
- One natural sub-module, mc_alu_dec: maps state-class, funct3 and funct7b5 to alu_op plus a legal flag.

## Test plan
- lw (opcode 0000011) with mem_ready=1: state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write only in cycle 5, result_src=01; instret 0→1.
- sub (0110011, funct3 000, funct7b5 1): alu_op=001 in EXECR, reg_write in ALUWB; retires after 4 cycles.
- beq taken/not-taken: zero=1 gives pc_write=1 in BRANCH; zero=0 gives pc_write=0. Both pulse instr_done.
- sw with mem_ready low for 3 cycles: mem_write and adr_src=1 held 3 cycles. The sw retires in the cycle mem_ready rises, 7 cycles total.
- Opcode 1101111, and separately 0110011 with funct3 100: ILLEGAL entered, illegal=1 and no further strobes for 10 cycles. Reset clears it and returns to FETCH.
- Reset asserted during MEMREAD: next cycle is FETCH, instret=0, no reg_write observed.
